// File: rtl/lehmer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lehmer_seq
//  Purpose  : Park-Miller minimal-standard Lehmer generator using Schrage's
//             method. The state/Q division runs on an external divider
//             through a start/done handshake; the remaining arithmetic
//             (A*lo - R*hi, wrap by M) is done locally in one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module lehmer_seq #(
    parameter int A       = 16807,
    parameter int M       = 2147483647,
    parameter int Q       = 127773,
    parameter int R       = 2836,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed_in,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic [31:0] rnd,
    output logic        err,
    output logic        div_en,
    output logic [31:0] div_y,
    output logic [31:0] div_x,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic        div_done
);

    localparam int                  c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [31:0]         c_m     = 32'(M);
    localparam logic [31:0]         c_q     = 32'(Q);
    localparam logic signed [33:0]  c_a_s   = 34'(A);
    localparam logic signed [33:0]  c_r_s   = 34'(R);
    localparam logic signed [33:0]  c_m_s   = 34'(M);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CALC  = 2'd3
    } state_t;

    state_t               r_fsm;
    logic [31:0]          r_state;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_div_y;
    logic [31:0]          r_div_x;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_div_en;

    logic                 w_seed_ok;
    logic signed [33:0]   w_lo_s;
    logic signed [33:0]   w_hi_s;
    logic signed [33:0]   w_test;
    logic [31:0]          w_next;

    // Seeds of 0 or >= M would lock the generator or leave its range.
    assign w_seed_ok = (seed_in != 32'd0) && (seed_in < c_m);

    // Schrage step: lo < Q keeps A*lo below 2^31, so 34 signed bits suffice.
    assign w_lo_s = $signed({2'b00, r_lo});
    assign w_hi_s = $signed({2'b00, r_hi});
    assign w_test = (c_a_s * w_lo_s) - (c_r_s * w_hi_s);
    assign w_next = (w_test > 34'sd0) ? 32'(w_test) : 32'(w_test + c_m_s);

    assign busy   = (r_fsm != IDLE);
    assign valid  = r_valid;
    assign rnd    = r_state;
    assign err    = r_err;
    assign div_en = r_div_en;
    assign div_y  = r_div_y;
    assign div_x  = r_div_x;

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm    <= IDLE;
            r_state  <= 32'd1;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_div_y  <= 32'd0;
            r_div_x  <= 32'd0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_div_en <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_div_en <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    // load has priority; a simultaneous start is dropped
                    if (load) begin
                        r_state <= w_seed_ok ? seed_in : 32'd1;
                        r_err   <= 1'b0;
                    end else if (start) begin
                        // div_en/div_y/div_x become visible during ISSUE
                        r_div_en <= 1'b1;
                        r_div_y  <= r_state;
                        r_div_x  <= c_q;
                        r_fsm    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt <= '0;
                    r_fsm <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + c_one;
                    // cnt==0 is the first WAIT cycle: a done still held from
                    // the previous operation must not be taken as our result
                    if ((r_cnt != '0) && div_done) begin
                        r_hi  <= div_q;
                        r_lo  <= div_r;
                        r_fsm <= CALC;
                    end else if (r_cnt == c_last) begin
                        r_err <= 1'b1;
                        r_fsm <= IDLE;
                    end
                end
                CALC: begin
                    r_state <= w_next;
                    r_valid <= 1'b1;
                    r_fsm   <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lehmer_seq.md
LEHMER_SEQ -- requirements
Module: lehmer_seq

Interface
REQ-001 Parameter A, 16807, Park-Miller multiplier.
REQ-002 Parameter M, 2147483647, modulus (2^31-1).
REQ-003 Parameter Q, 127773, Schrage quotient M/A, driven as divisor.
REQ-004 Parameter R, 2836, Schrage remainder M%A.
REQ-005 Parameter TIMEOUT, 64, maximum WAIT cycles before abort.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  the single clock; all flops rising-edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 load  in  1  one-cycle request to load seed_in into the state register.
REQ-010 seed_in  in  32  seed value for load.
REQ-011 start  in  1  one-cycle request to compute the next state.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 valid  out  1  one-cycle pulse: rnd holds a new value.
REQ-014 rnd  out  32  current generator state; bit 31 always 0.
REQ-015 err  out  1  sticky divider-timeout flag.
REQ-016 div_en  out  1  one-cycle start pulse to the divider.
REQ-017 div_y  out  32  dividend to the divider.
REQ-018 div_x  out  32  divisor to the divider.
REQ-019 div_q  in  32  divider quotient.
REQ-020 div_r  in  32  divider remainder.
REQ-021 div_done  in  1  divider result valid; the divider drops it the cycle after sampling div_en.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, CALC.
REQ-023 IDLE, load=1: state <= seed_in if 1 <= seed_in <= M-1, else state <= 1; clear err; no valid pulse.
REQ-024 IDLE, start=1, load=0: go to ISSUE.
REQ-025 IDLE, load and start together: load wins and start is dropped.
REQ-026 busy high: load and start are ignored, not queued.
REQ-027 ISSUE: div_en=1 for exactly this cycle, with div_y=state and div_x=Q; clear the WAIT counter; go to WAIT.
REQ-028 div_y and div_x hold their values from ISSUE until the FSM returns to IDLE.
REQ-029 WAIT, first cycle: ignore div_done (stale-done guard).
REQ-030 WAIT, later cycles: on div_done=1, capture hi=div_q and lo=div_r, then go to CALC.
REQ-031 WAIT: increment the counter every cycle; if it reaches TIMEOUT with no capture, set err, go to IDLE, leave state unchanged, no valid.
REQ-032 CALC arithmetic: test = A*lo - R*hi, signed, at least 33 bits.
REQ-033 CALC result: next = test if test > 0, else test + M.
REQ-034 CALC update: state <= next, valid <= 1 (registered), go to IDLE.
REQ-035 Latency: valid is high the cycle after CALC, i.e. 2 cycles after the div_done capture cycle.
REQ-036 Without a timeout, start-to-valid is 4 + (cycles from div_en to div_done beyond the guard).
REQ-037 rnd is the registered state and changes only on load or CALC.
REQ-038 Result range: always 1..M-1, never 0 or M.
REQ-039 div_en is never asserted outside ISSUE.

Reset
REQ-040 rst_n low: FSM=IDLE, state=1, rnd=1, valid=0, busy=0, err=0, div_en=0, div_y=0, div_x=0, WAIT counter=0.
REQ-041 Reset asserted mid-operation: abort immediately; an in-flight divider result is never captured.
REQ-042 After release: the first start computes from state=1.

Verification
REQ-043 Reset, then start with a behavioural divider -> rnd=16807, valid one cycle, div_y=1 and div_x=127773 during ISSUE.
REQ-044 load seed_in=16807, then start -> rnd=282475249; load seed_in=0 or 0x7FFFFFFF -> rnd=1.
REQ-045 From seed 1, 10000 chained starts -> rnd=1043618065; no div_en outside ISSUE; valid count 10000.
REQ-046 Divider holds div_done=1 from the previous op on the first WAIT cycle -> not captured; capture occurs on the true done.
REQ-047 Divider never asserts done -> err=1 after TIMEOUT WAIT cycles, FSM in IDLE, rnd unchanged; a later load clears err.
REQ-048 Events during operation -> start and load asserted while busy are ignored; simultaneous load and start in IDLE loads only; rst_n pulsed during WAIT gives rnd=1, busy=0, and a stale div_done then causes no valid.
